sdrc_traffic_checker: RTL and testbench



---
 rtl/sdrc_traffic_checker.sv | 249 ++++++++++++++++++++++++
 tb/tb_sdrc_traffic_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_traffic_checker.sv
// sdrc_traffic_checker
//   Write/read-back traffic generator and data checker for the SDRAM
//   controller user port. Each burst pair writes BURST_LEN words from the
//   selected pattern, reads them back, and compares word by word.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   I_start / I_stop         run control (start accepted in IDLE/DONE only)
//   I_mode                   0 incrementing, 1 PRBS, 2 walking-one, 3 address
//   I_num_bursts             burst pairs to run, 0 = continuous
//   I_base_addr, I_seed      first burst address, pattern seed
//   I_sdrc_*                 controller status and read-data return
//   O_sdrc_*                 controller command / write-data interface
//   O_busy, O_done, O_pass   run status
//   O_err_cnt, O_timeout     error count (saturating), sticky watchdog flag
//   O_burst_cnt              completed burst pairs
//   O_first_err_*            address / expected / received of first bad word

module sdrc_traffic_checker #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 21,
   parameter int LEN_W     = 8,
   parameter int BURST_LEN = 26,
   parameter int TIMEOUT   = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                I_start,
   input  logic                I_stop,
   input  logic [1:0]          I_mode,
   input  logic [15:0]         I_num_bursts,
   input  logic [ADDR_W-1:0]   I_base_addr,
   input  logic [31:0]         I_seed,
   input  logic                I_sdrc_init_done,
   input  logic                I_sdrc_busy_n,
   input  logic                I_sdrc_rd_valid,
   input  logic [DATA_W-1:0]   I_sdrc_data,
   output logic                O_sdrc_wr_n,
   output logic                O_sdrc_rd_n,
   output logic [ADDR_W-1:0]   O_sdrc_addr,
   output logic [DATA_W-1:0]   O_sdrc_data,
   output logic [LEN_W-1:0]    O_sdrc_data_len,
   output logic [DATA_W/8-1:0] O_sdrc_dqm,
   output logic                O_sdrc_selfrefresh,
   output logic                O_sdrc_power_down,
   output logic                O_busy,
   output logic                O_done,
   output logic                O_pass,
   output logic [31:0]         O_err_cnt,
   output logic                O_timeout,
   output logic [15:0]         O_burst_cnt,
   output logic [ADDR_W-1:0]   O_first_err_addr,
   output logic [DATA_W-1:0]   O_first_err_exp,
   output logic [DATA_W-1:0]   O_first_err_got
);

   localparam int CNT_W = LEN_W + 1;               // holds 0..BURST_LEN
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int REP   = (DATA_W + 31) / 32;
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   typedef enum logic [2:0] {
      IDLE, WAIT_INIT, WR_REQ, WR_DATA, RD_REQ, RD_DATA, DONE
   } state_t;

   // Pattern state is one 32-bit word: a running count (modes 0/2/3) or the
   // LFSR (mode 1). Stepping it once per word keeps the stream continuous.
   function automatic logic [31:0] pat_step(input logic [1:0] mode, input logic [31:0] p);
      if (mode == 2'd1)
         return p[0] ? ((p >> 1) ^ LFSR_POLY) : (p >> 1);
      return p + 32'd1;
   endfunction

   function automatic logic [DATA_W-1:0] pat_word(input logic [1:0] mode, input logic [31:0] p,
                                                   input logic [ADDR_W-1:0] a);
      logic [REP*32-1:0] rep;
      logic [DATA_W-1:0] w;
      rep = {REP{p}};
      case (mode)
         2'd0:    w = DATA_W'(p);
         2'd1:    w = rep[DATA_W-1:0];
         2'd2:    w = DATA_W'(1) << p[$clog2(DATA_W)-1:0];
         default: w = DATA_W'(a);
      endcase
      return w;
   endfunction

   state_t            state;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wr_pat, save_pat, rd_pat;
   logic [CNT_W-1:0]  wr_idx, rd_idx;
   logic [WD_W-1:0]   wdog;
   logic              stop_pend, captured;

   logic              start_ok, in_rd, rd_hit, rd_last, mismatch, spurious, wd_fire, pass_nxt;
   logic [DATA_W-1:0] exp_word;
   logic [32:0]       err_add, err_sum;
   logic [31:0]       err_nxt;

   // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
   always_comb begin
      start_ok = I_start && (state == IDLE || state == DONE);
      in_rd    = (state == RD_DATA);
      exp_word = pat_word(mode_q, rd_pat, addr + ADDR_W'(rd_idx));
      rd_hit   = in_rd && I_sdrc_rd_valid;
      rd_last  = rd_hit && (rd_idx == CNT_W'(BURST_LEN - 1));
      mismatch = rd_hit && (I_sdrc_data != exp_word);
      spurious = !in_rd && I_sdrc_rd_valid;
      wd_fire  = in_rd && !rd_last && (wdog == WD_W'(TIMEOUT - 1));
      err_add  = 33'(mismatch || spurious);
      // On watchdog expiry every word not yet received counts as an error.
      if (wd_fire)
         err_add = err_add + 33'(BURST_LEN) - 33'(rd_idx) - 33'(rd_hit);
      err_sum  = {1'b0, O_err_cnt} + err_add;
      err_nxt  = err_sum[32] ? '1 : err_sum[31:0];
      pass_nxt = (err_nxt == 32'd0) && !O_timeout && !wd_fire;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and takes priority over everything, including the strobes.
      if (rst) begin
         state            <= IDLE;
         mode_q           <= 2'd0;
         addr             <= '0;
         wr_pat           <= '0;
         save_pat         <= '0;
         rd_pat           <= '0;
         wr_idx           <= '0;
         rd_idx           <= '0;
         wdog             <= '0;
         stop_pend        <= 1'b0;
         captured         <= 1'b0;
         O_sdrc_wr_n      <= 1'b1;
         O_sdrc_rd_n      <= 1'b1;
         O_sdrc_addr      <= '0;
         O_sdrc_data      <= '0;
         O_pass           <= 1'b0;
         O_err_cnt        <= '0;
         O_timeout        <= 1'b0;
         O_burst_cnt      <= '0;
         O_first_err_addr <= '0;
         O_first_err_exp  <= '0;
         O_first_err_got  <= '0;
      end else begin
         O_sdrc_wr_n <= 1'b1;
         O_sdrc_rd_n <= 1'b1;
         if (start_ok) begin
            state            <= WAIT_INIT;
            mode_q           <= I_mode;
            addr             <= I_base_addr;
            // An all-zero LFSR would lock up, so a zero PRBS seed becomes 1.
            wr_pat           <= (I_mode == 2'd1 && I_seed == 32'd0) ? 32'd1 : I_seed;
            stop_pend        <= 1'b0;
            captured         <= 1'b0;
            O_pass           <= 1'b0;
            O_err_cnt        <= '0;
            O_timeout        <= 1'b0;
            O_burst_cnt      <= '0;
            O_first_err_addr <= '0;
            O_first_err_exp  <= '0;
            O_first_err_got  <= '0;
         end else begin
            O_err_cnt <= err_nxt;
            if ((mismatch || spurious) && !captured) begin
               captured         <= 1'b1;
               O_first_err_addr <= mismatch ? addr + ADDR_W'(rd_idx) : O_sdrc_addr;
               O_first_err_exp  <= mismatch ? exp_word : '0;
               O_first_err_got  <= I_sdrc_data;
            end
            if (I_stop && O_busy)
               stop_pend <= 1'b1;

            case (state)
               WAIT_INIT: begin
                  if (I_stop) begin
                     state  <= DONE;
                     O_pass <= pass_nxt;
                  end else if (I_sdrc_init_done) begin
                     state <= WR_REQ;
                  end
               end
               WR_REQ: begin
                  if (I_sdrc_busy_n) begin
                     O_sdrc_wr_n <= 1'b0;
                     O_sdrc_addr <= addr;
                     O_sdrc_data <= pat_word(mode_q, wr_pat, addr);
                     save_pat    <= wr_pat;
                     wr_pat      <= pat_step(mode_q, wr_pat);
                     wr_idx      <= CNT_W'(1);
                     state       <= (BURST_LEN == 1) ? RD_REQ : WR_DATA;
                  end
               end
               WR_DATA: begin
                  O_sdrc_data <= pat_word(mode_q, wr_pat, addr + ADDR_W'(wr_idx));
                  wr_pat      <= pat_step(mode_q, wr_pat);
                  wr_idx      <= wr_idx + CNT_W'(1);
                  if (wr_idx == CNT_W'(BURST_LEN - 1))
                     state <= RD_REQ;
               end
               RD_REQ: begin
                  if (I_sdrc_busy_n) begin
                     O_sdrc_rd_n <= 1'b0;
                     O_sdrc_addr <= addr;
                     rd_pat      <= save_pat;  // replay the burst's write stream
                     rd_idx      <= '0;
                     wdog        <= '0;
                     state       <= RD_DATA;
                  end
               end
               RD_DATA: begin
                  wdog <= wdog + WD_W'(1);
                  if (rd_hit) begin
                     rd_pat <= pat_step(mode_q, rd_pat);
                     rd_idx <= rd_idx + CNT_W'(1);
                  end
                  if (rd_last) begin
                     O_burst_cnt <= O_burst_cnt + 16'd1;
                     addr        <= addr + ADDR_W'(BURST_LEN);
                     if ((I_num_bursts != 16'd0 && O_burst_cnt + 16'd1 == I_num_bursts) ||
                         stop_pend || I_stop) begin
                        state  <= DONE;
                        O_pass <= pass_nxt;
                     end else begin
                        state <= WR_REQ;
                     end
                  end else if (wd_fire) begin
                     O_timeout <= 1'b1;
                     state     <= DONE;
                     O_pass    <= pass_nxt;
                  end
               end
               DONE:    O_pass <= pass_nxt;  // spurious words in DONE still drop pass
               IDLE:    ;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign O_busy             = (state != IDLE) && (state != DONE);
   assign O_done             = (state == DONE);
   assign O_sdrc_data_len    = LEN_W'(BURST_LEN - 1);
   assign O_sdrc_dqm         = '0;
   assign O_sdrc_selfrefresh = 1'b0;
   assign O_sdrc_power_down  = 1'b0;

endmodule

// File: tb/tb_sdrc_traffic_checker.sv
// tb_sdrc_traffic_checker
//   Directed bench for sdrc_traffic_checker with default parameters. A small
//   SDRAM model stores written bursts and returns them on reads; it can flip
//   one bit of one word, or suppress read data entirely.

module tb_sdrc_traffic_checker;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 21;
   localparam int LEN_W  = 8;
   localparam int BL     = 26;

   logic                clk = 1'b0;
   logic                rst;
   logic                I_start, I_stop;
   logic [1:0]          I_mode;
   logic [15:0]         I_num_bursts;
   logic [ADDR_W-1:0]   I_base_addr;
   logic [31:0]         I_seed;
   logic                I_sdrc_init_done, I_sdrc_busy_n;
   logic                I_sdrc_rd_valid;
   logic [DATA_W-1:0]   I_sdrc_data;
   logic                O_sdrc_wr_n, O_sdrc_rd_n;
   logic [ADDR_W-1:0]   O_sdrc_addr;
   logic [DATA_W-1:0]   O_sdrc_data;
   logic [LEN_W-1:0]    O_sdrc_data_len;
   logic [DATA_W/8-1:0] O_sdrc_dqm;
   logic                O_sdrc_selfrefresh, O_sdrc_power_down;
   logic                O_busy, O_done, O_pass, O_timeout;
   logic [31:0]         O_err_cnt;
   logic [15:0]         O_burst_cnt;
   logic [ADDR_W-1:0]   O_first_err_addr;
   logic [DATA_W-1:0]   O_first_err_exp, O_first_err_got;

   logic                m_valid, inj_valid;
   logic [DATA_W-1:0]   m_data, inj_data;

   assign I_sdrc_rd_valid = m_valid | inj_valid;
   assign I_sdrc_data     = inj_valid ? inj_data : m_data;

   always #5 clk = ~clk;

   sdrc_traffic_checker dut (
      .clk(clk), .rst(rst),
      .I_start(I_start), .I_stop(I_stop), .I_mode(I_mode),
      .I_num_bursts(I_num_bursts), .I_base_addr(I_base_addr), .I_seed(I_seed),
      .I_sdrc_init_done(I_sdrc_init_done), .I_sdrc_busy_n(I_sdrc_busy_n),
      .I_sdrc_rd_valid(I_sdrc_rd_valid), .I_sdrc_data(I_sdrc_data),
      .O_sdrc_wr_n(O_sdrc_wr_n), .O_sdrc_rd_n(O_sdrc_rd_n),
      .O_sdrc_addr(O_sdrc_addr), .O_sdrc_data(O_sdrc_data),
      .O_sdrc_data_len(O_sdrc_data_len), .O_sdrc_dqm(O_sdrc_dqm),
      .O_sdrc_selfrefresh(O_sdrc_selfrefresh), .O_sdrc_power_down(O_sdrc_power_down),
      .O_busy(O_busy), .O_done(O_done), .O_pass(O_pass),
      .O_err_cnt(O_err_cnt), .O_timeout(O_timeout), .O_burst_cnt(O_burst_cnt),
      .O_first_err_addr(O_first_err_addr), .O_first_err_exp(O_first_err_exp),
      .O_first_err_got(O_first_err_got)
   );

   // ---------------- SDRAM model (samples on negedge) ----------------
   logic [31:0]       mem [int];
   logic [31:0]       wr_words [$];
   logic [ADDR_W-1:0] cmd_addr [$];
   int                rd_cmds;
   int                fault_burst;
   bit                suppress;

   initial begin : sdram_model
      logic [ADDR_W-1:0] wa, ra, a;
      int wr_left, wr_i, rd_left, rd_i, rd_dly, cyc, burst_no;
      wr_left = 0; wr_i = 0; rd_left = 0; rd_i = 0; rd_dly = 0; cyc = 0; burst_no = 0;
      wa = '0; ra = '0; a = '0;
      rd_cmds = 0;
      m_valid = 1'b0;
      m_data = '0;
      I_sdrc_busy_n = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         I_sdrc_busy_n = (cyc % 5) != 0;
         m_valid = 1'b0;
         if (rst) begin
            wr_left = 0;
            rd_left = 0;
         end else begin
            if (!O_sdrc_wr_n) begin
               wa = O_sdrc_addr;
               mem[int'(wa)] = O_sdrc_data;
               wr_words.push_back(O_sdrc_data);
               cmd_addr.push_back(wa);
               wr_i = 1;
               wr_left = BL - 1;
            end else if (wr_left > 0) begin
               a = wa + ADDR_W'(wr_i);
               mem[int'(a)] = O_sdrc_data;
               wr_words.push_back(O_sdrc_data);
               wr_i++;
               wr_left--;
            end
            if (!O_sdrc_rd_n) begin
               ra = O_sdrc_addr;
               rd_i = 0;
               rd_left = BL;
               rd_dly = 3;
               burst_no = rd_cmds;
               rd_cmds++;
            end else if (rd_left > 0) begin
               if (rd_dly > 0) begin
                  rd_dly--;
               end else begin
                  a = ra + ADDR_W'(rd_i);
                  m_data = mem.exists(int'(a)) ? mem[int'(a)] : 32'd0;
                  if (burst_no == fault_burst && rd_i == 5)
                     m_data ^= 32'h8;
                  m_valid = !suppress;
                  rd_i++;
                  rd_left--;
               end
            end
         end
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   int n;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [1:0] mode, input logic [31:0] seed,
                            input logic [15:0] nb, input logic [ADDR_W-1:0] base);
      @(negedge clk);
      wr_words.delete();
      cmd_addr.delete();
      I_mode = mode;
      I_seed = seed;
      I_num_bursts = nb;
      I_base_addr = base;
      I_start = 1'b1;
      @(negedge clk);
      I_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (O_done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, " done"}, O_done, 1);
   endtask

   initial begin
      rst = 1'b1;
      I_start = 1'b0; I_stop = 1'b0; I_mode = 2'd0; I_num_bursts = 16'd0;
      I_base_addr = '0; I_seed = '0; I_sdrc_init_done = 1'b0;
      inj_valid = 1'b0; inj_data = '0;
      fault_burst = -1; suppress = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst wr_n", O_sdrc_wr_n, 1);
      check("rst rd_n", O_sdrc_rd_n, 1);
      check("rst addr", O_sdrc_addr, 0);
      check("rst data", O_sdrc_data, 0);
      check("rst busy", O_busy, 0);
      check("rst done", O_done, 0);
      check("rst err", O_err_cnt, 0);
      check("data_len", O_sdrc_data_len, 25);
      rst = 1'b0;

      // Clean incrementing run, controller initialisation delayed
      start_run(2'd0, 32'd0, 16'd4, 21'h100);
      repeat (4) @(negedge clk);
      check("wait_init busy", O_busy, 1);
      check("wait_init no wr", O_sdrc_wr_n, 1);
      I_sdrc_init_done = 1'b1;
      wait_done("inc", 2000);
      check("inc pass", O_pass, 1);
      check("inc err", O_err_cnt, 0);
      check("inc bursts", O_burst_cnt, 4);
      check("inc addr0", cmd_addr[0], 21'h100);
      check("inc addr1", cmd_addr[1], 21'h11A);
      check("inc addr2", cmd_addr[2], 21'h134);
      check("inc addr3", cmd_addr[3], 21'h14E);
      check("inc nwords", wr_words.size(), 104);
      check("inc w0", wr_words[0], 32'd0);
      check("inc w25", wr_words[25], 32'd25);
      check("inc w103", wr_words[103], 32'd103);

      // PRBS with zero seed
      start_run(2'd1, 32'd0, 16'd1, 21'h500);
      wait_done("prbs", 1000);
      check("prbs w0", wr_words[0], 32'h1);
      check("prbs w1", wr_words[1], 32'h80200003);
      check("prbs w2", wr_words[2], 32'hC0300002);
      check("prbs pass", O_pass, 1);

      // Walking one from bit 30, wrapping modulo 32
      start_run(2'd2, 32'd30, 16'd2, 21'h600);
      wait_done("walk", 1000);
      check("walk w0", wr_words[0], 32'h40000000);
      check("walk w1", wr_words[1], 32'h80000000);
      check("walk w2", wr_words[2], 32'h00000001);
      check("walk w27", wr_words[27], 32'h02000000);
      check("walk pass", O_pass, 1);

      // Address-as-data across the top of the address space
      start_run(2'd3, 32'h1234, 16'd2, 21'h1FFFF0);
      wait_done("adr", 1000);
      check("adr w0", wr_words[0], 32'h1FFFF0);
      check("adr w16", wr_words[16], 32'h0);
      check("adr w26", wr_words[26], 32'hA);
      check("adr cmd1", cmd_addr[1], 21'hA);
      check("adr pass", O_pass, 1);

      // Single-bit fault: bit 3 of word 5 in burst 1
      fault_burst = rd_cmds + 1;
      start_run(2'd0, 32'd0, 16'd3, 21'h2000);
      wait_done("fault", 2000);
      fault_burst = -1;
      check("fault err", O_err_cnt, 1);
      check("fault addr", O_first_err_addr, 21'h201F);
      check("fault exp", O_first_err_exp, 32'h1F);
      check("fault got", O_first_err_got, 32'h17);
      check("fault pass", O_pass, 0);
      check("fault bursts", O_burst_cnt, 3);

      // Missing read data -> watchdog
      suppress = 1'b1;
      start_run(2'd0, 32'd0, 16'd4, 21'h0);
      n = 0;
      while (O_sdrc_rd_n !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("to rd issued", O_sdrc_rd_n, 0);
      n = 0;
      while (O_timeout !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("to latency", n, 1024);
      check("to flag", O_timeout, 1);
      check("to done", O_done, 1);
      check("to err", O_err_cnt, 26);
      check("to pass", O_pass, 0);
      check("to bursts", O_burst_cnt, 0);
      suppress = 1'b0;

      // Stop during burst 3 writes in continuous mode; start while busy ignored
      start_run(2'd0, 32'd0, 16'd0, 21'h300);
      n = 0;
      while (cmd_addr.size() < 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("stop third wr", cmd_addr.size(), 3);
      repeat (3) @(negedge clk);
      I_stop = 1'b1;
      @(negedge clk);
      I_stop = 1'b0;
      I_start = 1'b1;
      @(negedge clk);
      I_start = 1'b0;
      wait_done("stop", 2000);
      check("stop bursts", O_burst_cnt, 3);
      check("stop err", O_err_cnt, 0);
      check("stop pass", O_pass, 1);
      check("stop ncmd", cmd_addr.size(), 3);
      inj_data = 32'hDEAD;
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      check("spur err", O_err_cnt, 1);
      check("spur got", O_first_err_got, 32'hDEAD);
      check("spur exp", O_first_err_exp, 32'h0);
      check("spur addr", O_first_err_addr, 21'h334);
      check("spur pass", O_pass, 0);

      // Reset during read data, then a normal run
      start_run(2'd0, 32'hFFFFFFFE, 16'd2, 21'h40);
      n = 0;
      while (O_sdrc_rd_n !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("mid rd issued", O_sdrc_rd_n, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid rst wr_n", O_sdrc_wr_n, 1);
      check("mid rst rd_n", O_sdrc_rd_n, 1);
      check("mid rst addr", O_sdrc_addr, 0);
      check("mid rst data", O_sdrc_data, 0);
      check("mid rst busy", O_busy, 0);
      check("mid rst done", O_done, 0);
      check("mid rst err", O_err_cnt, 0);
      check("mid rst bursts", O_burst_cnt, 0);
      check("mid rst faddr", O_first_err_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      start_run(2'd0, 32'hFFFFFFFE, 16'd2, 21'h40);
      wait_done("rerun", 2000);
      check("rerun pass", O_pass, 1);
      check("rerun bursts", O_burst_cnt, 2);
      check("rerun w0", wr_words[0], 32'hFFFFFFFE);
      check("rerun w2", wr_words[2], 32'h0);
      check("rerun w51", wr_words[51], 32'h31);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
